program_loader: RTL

//  Encoder-side counterpart of the instruction decoder: takes structured op requests (class, regs, funct, imm)

---
 rtl/program_loader_pkg.sv | 55 +++++
 rtl/rv32i_instr_encoder.sv | 50 +++++
 rtl/program_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared RV32I encoding constants, op-request payload and loader state type.
package program_loader_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPCLASS_W = 4;
    localparam int unsigned REG_W     = 5;

    // Major opcodes, instr[6:2]; the low two bits are always 2'b11.
    localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
    localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
    localparam logic [4:0] OPCODE_STORE  = 5'b01000;
    localparam logic [4:0] OPCODE_OP     = 5'b01100;
    localparam logic [4:0] OPCODE_LUI    = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;

    localparam logic [OPCLASS_W-1:0] OPCLASS_R       = 4'd0;
    localparam logic [OPCLASS_W-1:0] OPCLASS_I_ARITH = 4'd1;
    localparam logic [OPCLASS_W-1:0] OPCLASS_LOAD    = 4'd2;
    localparam logic [OPCLASS_W-1:0] OPCLASS_STORE   = 4'd3;
    localparam logic [OPCLASS_W-1:0] OPCLASS_BRANCH  = 4'd4;
    localparam logic [OPCLASS_W-1:0] OPCLASS_JALR    = 4'd5;
    localparam logic [OPCLASS_W-1:0] OPCLASS_JAL     = 4'd6;
    localparam logic [OPCLASS_W-1:0] OPCLASS_AUIPC   = 4'd7;
    localparam logic [OPCLASS_W-1:0] OPCLASS_LUI     = 4'd8;
    localparam logic [OPCLASS_W-1:0] OPCLASS_SYSTEM  = 4'd9;

    localparam logic [XLEN-1:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0] INSTR_EBREAK = 32'h0010_0073;

    typedef struct packed {
        logic [OPCLASS_W-1:0] op_class;
        logic [REG_W-1:0]     rd;
        logic [REG_W-1:0]     rs1;
        logic [REG_W-1:0]     rs2;
        logic [2:0]           funct3;
        logic                 f7b5;
        logic [XLEN-1:0]      imm;
    } op_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TERM,
        ST_DONE
    } load_state_t;

    function automatic logic [6:0] opc(input logic [4:0] code);
        return {code, 2'b11};
    endfunction

endpackage

// File: rtl/rv32i_instr_encoder.sv
// Combinational op-request to RV32I instruction word encoder.
module rv32i_instr_encoder
    import program_loader_pkg::*;
(
    input  op_req_t         req,
    output logic [XLEN-1:0] word,
    output logic            illegal
);

    // Bit 0 of B/J offsets is implied by the ISA and never encoded.
    logic unused_imm0;
    assign unused_imm0 = req.imm[0];

    always_comb begin
        word    = INSTR_NOP;
        illegal = 1'b0;
        case (req.op_class)
            OPCLASS_R:
                word = {1'b0, req.f7b5, 5'b0, req.rs2, req.rs1, req.funct3, req.rd, opc(OPCODE_OP)};
            OPCLASS_I_ARITH: begin
                if (req.funct3 == 3'b001 || req.funct3 == 3'b101)
                    word = {1'b0, req.f7b5, 5'b0, req.imm[4:0], req.rs1, req.funct3, req.rd,
                            opc(OPCODE_OP_IMM)};
                else
                    word = {req.imm[11:0], req.rs1, req.funct3, req.rd, opc(OPCODE_OP_IMM)};
            end
            OPCLASS_LOAD:
                word = {req.imm[11:0], req.rs1, req.funct3, req.rd, opc(OPCODE_LOAD)};
            OPCLASS_JALR:
                word = {req.imm[11:0], req.rs1, 3'b000, req.rd, opc(OPCODE_JALR)};
            OPCLASS_STORE:
                word = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], opc(OPCODE_STORE)};
            OPCLASS_BRANCH:
                word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                        req.imm[4:1], req.imm[11], opc(OPCODE_BRANCH)};
            OPCLASS_JAL:
                word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd,
                        opc(OPCODE_JAL)};
            OPCLASS_AUIPC:
                word = {req.imm[31:12], req.rd, opc(OPCODE_AUIPC)};
            OPCLASS_LUI:
                word = {req.imm[31:12], req.rd, opc(OPCODE_LUI)};
            OPCLASS_SYSTEM:
                word = req.f7b5 ? INSTR_EBREAK : INSTR_ECALL;
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/program_loader.sv
// Streams encoded RV32I ops into IMEM and closes each session with an ECALL terminator.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [3:0]                   op_class,
    input  logic [4:0]                   op_rd,
    input  logic [4:0]                   op_rs1,
    input  logic [4:0]                   op_rs2,
    input  logic [2:0]                   op_funct3,
    input  logic                         op_f7b5,
    input  logic [31:0]                  op_imm,
    input  logic                         op_last,
    output logic                         imem_we,
    output logic [31:0]                  imem_addr,
    output logic [31:0]                  imem_wdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err_illegal,
    output logic                         err_overflow,
    output logic [$clog2(DEPTH+1)-1:0]   word_count
);

    localparam int unsigned CW        = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);

    op_req_t         req;
    logic [XLEN-1:0] enc_word;
    logic            enc_illegal;

    assign req = '{op_class: op_class, rd: op_rd, rs1: op_rs1, rs2: op_rs2,
                   funct3: op_funct3, f7b5: op_f7b5, imm: op_imm};

    rv32i_instr_encoder u_encoder (
        .req     (req),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    load_state_t   state, state_n;
    logic          op_ready_n, imem_we_n, busy_n, done_n, err_ill_n, err_ovf_n;
    logic [31:0]   imem_addr_n, imem_wdata_n;
    logic [CW-1:0] count_n;
    logic [31:0]   slot_addr;
    logic          accept;

    assign accept    = op_valid & op_ready;
    assign slot_addr = BASE_ADDR + 32'({word_count, 2'b00});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            op_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'h0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            word_count   <= '0;
        end else begin
            state        <= state_n;
            op_ready     <= op_ready_n;
            imem_we      <= imem_we_n;
            imem_addr    <= imem_addr_n;
            imem_wdata   <= imem_wdata_n;
            busy         <= busy_n;
            done         <= done_n;
            err_illegal  <= err_ill_n;
            err_overflow <= err_ovf_n;
            word_count   <= count_n;
        end
    end

    // Next-state and next-output logic; the write strobe is a single-cycle pulse.
    always_comb begin
        state_n      = state;
        op_ready_n   = op_ready;
        imem_we_n    = 1'b0;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        busy_n       = busy;
        done_n       = done;
        err_ill_n    = err_illegal;
        err_ovf_n    = err_overflow;
        count_n      = word_count;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n     = ST_LOAD;
                    op_ready_n  = 1'b1;
                    imem_addr_n = BASE_ADDR;
                    busy_n      = 1'b1;
                    done_n      = 1'b0;
                    err_ill_n   = 1'b0;
                    err_ovf_n   = 1'b0;
                    count_n     = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    imem_we_n    = 1'b1;
                    imem_addr_n  = slot_addr;
                    imem_wdata_n = enc_word;
                    count_n      = word_count + CW'(1);
                    if (enc_illegal)
                        err_ill_n = 1'b1;
                    // The final slot is reserved for the terminator.
                    if (op_last || count_n == LAST_SLOT) begin
                        state_n    = ST_TERM;
                        op_ready_n = 1'b0;
                        if (!op_last)
                            err_ovf_n = 1'b1;
                    end
                end
            end
            ST_TERM: begin
                imem_we_n    = 1'b1;
                imem_addr_n  = slot_addr;
                imem_wdata_n = INSTR_ECALL;
                count_n      = word_count + CW'(1);
                state_n      = ST_DONE;
                busy_n       = 1'b0;
                done_n       = 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
